// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver state encoding, parity
//               mode encodings and the default oversampling ratio.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Both 00 and 11 mean "no parity bit on the line".
    function automatic logic par_enabled(input logic [1:0] p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Serial line, frame configuration and received-frame result
//               bundle of the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;

    logic       stream_in;
    logic       d_num;
    logic       s_num;
    logic [1:0] par;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_active;

    modport master (
        output stream_in, d_num, s_num, par,
        input  data_out, data_valid, parity_err, frame_err, rx_active
    );

    modport slave (
        input  stream_in, d_num, s_num, par,
        output data_out, data_valid, parity_err, frame_err, rx_active
    );

endinterface
`default_nettype wire

// File: rtl/rx_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module      : rx_bit_sampler
// Description : Line synchronizer, falling-edge detect and 3-sample majority
//               vote around the middle of each bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_bit_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int PHASE_W    = 4
) (
    input  logic               tick,
    input  logic               reset_n,
    input  logic               stream_in,
    input  logic [PHASE_W-1:0] phase,
    output logic               sync_line,
    output logic               fall,
    output logic               bit_value
);

    localparam logic [PHASE_W-1:0] c_phase_a = PHASE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PHASE_W-1:0] c_phase_b = PHASE_W'(OVERSAMPLE / 2);
    localparam logic [PHASE_W-1:0] c_phase_c = PHASE_W'(OVERSAMPLE / 2 + 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [2:0] r_samples;

    // Flops reset to the idle (high) line level so no false edge follows reset.
    always_ff @(posedge tick or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_prev    <= 1'b1;
            r_samples <= 3'b111;
        end else begin
            r_sync1 <= stream_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (phase == c_phase_a) r_samples[0] <= r_sync2;
            if (phase == c_phase_b) r_samples[1] <= r_sync2;
            if (phase == c_phase_c) r_samples[2] <= r_sync2;
        end
    end

    assign sync_line = r_sync2;
    assign fall      = r_prev & ~r_sync2;
    assign bit_value = (r_samples[0] & r_samples[1]) |
                       (r_samples[0] & r_samples[2]) |
                       (r_samples[1] & r_samples[2]);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver, 7/8 data bits, none/even/odd
//               parity, 1/2 stop bits; one-tick data_valid per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic     tick,
    input  logic     reset_n,
    uart_rx_if.slave rx
);

    import uart_pkg::*;

    localparam int                   c_phase_w    = $clog2(OVERSAMPLE);
    localparam logic [c_phase_w-1:0] c_last_phase = c_phase_w'(OVERSAMPLE - 1);
    localparam logic [c_phase_w-1:0] c_phase_one  = c_phase_w'(1);

    state_t               r_state;
    logic [c_phase_w-1:0] r_phase;
    logic [2:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic [7:0]           r_shift;
    logic                 r_armed;
    logic                 r_cfg_d8;
    logic                 r_cfg_s2;
    logic [1:0]           r_cfg_par;
    logic                 r_par_acc;
    logic                 r_perr_acc;
    logic                 r_ferr_acc;
    logic [7:0]           r_data_out;
    logic                 r_data_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_rx_active;

    logic                 w_line;
    logic                 w_fall;
    logic                 w_bit;
    logic                 w_bit_end;
    logic [2:0]           w_last_bit;

    rx_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .PHASE_W    (c_phase_w)
    ) u_sampler (
        .tick      (tick),
        .reset_n   (reset_n),
        .stream_in (rx.stream_in),
        .phase     (r_phase),
        .sync_line (w_line),
        .fall      (w_fall),
        .bit_value (w_bit)
    );

    assign w_bit_end  = (r_phase == c_last_phase);
    assign w_last_bit = r_cfg_d8 ? 3'd7 : 3'd6;

    always_ff @(posedge tick or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            r_bit_cnt    <= 3'd0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= 8'h00;
            r_armed      <= 1'b0;
            r_cfg_d8     <= 1'b0;
            r_cfg_s2     <= 1'b0;
            r_cfg_par    <= PAR_NONE0;
            r_par_acc    <= 1'b0;
            r_perr_acc   <= 1'b0;
            r_ferr_acc   <= 1'b0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_active  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            // A held-low line never re-arms, so a break yields one frame only.
            r_armed      <= r_armed | w_line;

            if (r_state == START || r_state == DATA ||
                r_state == PARITY || r_state == STOP) begin
                r_phase <= w_bit_end ? '0 : r_phase + c_phase_one;
            end else begin
                r_phase <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (r_armed && w_fall) begin
                        r_state     <= START;
                        r_armed     <= 1'b0;
                        r_rx_active <= 1'b1;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        if (!w_bit) begin
                            r_state    <= DATA;
                            r_cfg_d8   <= rx.d_num;
                            r_cfg_s2   <= rx.s_num;
                            r_cfg_par  <= rx.par;
                            r_bit_cnt  <= 3'd0;
                            r_par_acc  <= 1'b0;
                            r_perr_acc <= 1'b0;
                            r_ferr_acc <= 1'b0;
                        end else begin
                            r_state     <= IDLE;
                            r_rx_active <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_par_acc <= r_par_acc ^ w_bit;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == w_last_bit) begin
                            r_state    <= par_enabled(r_cfg_par) ? PARITY : STOP;
                            r_stop_cnt <= 1'b0;
                        end
                    end
                end

                PARITY: begin
                    if (w_bit_end) begin
                        r_perr_acc <= (r_cfg_par == PAR_ODD) ? ~(r_par_acc ^ w_bit)
                                                             :  (r_par_acc ^ w_bit);
                        r_state    <= STOP;
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        r_ferr_acc <= r_ferr_acc | ~w_bit;
                        if (r_stop_cnt == r_cfg_s2) begin
                            r_state <= DONE;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // In 7-bit mode the frame sits in bits [7:1] of the shifter.
                    r_data_out   <= r_cfg_d8 ? r_shift : {1'b0, r_shift[7:1]};
                    r_parity_err <= par_enabled(r_cfg_par) ? r_perr_acc : 1'b0;
                    r_frame_err  <= r_ferr_acc;
                    r_data_valid <= 1'b1;
                    r_state      <= IDLE;
                    r_rx_active  <= 1'b0;
                end

                default: begin
                    r_state     <= IDLE;
                    r_rx_active <= 1'b0;
                end
            endcase
        end
    end

    assign rx.data_out   = r_data_out;
    assign rx.data_valid = r_data_valid;
    assign rx.parity_err = r_parity_err;
    assign rx.frame_err  = r_frame_err;
    assign rx.rx_active  = r_rx_active;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed frames into uart_rx, checked against a frame-level
//               scoreboard on every tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    import uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         lat;
    } exp_t;

    logic tick    = 1'b0;
    logic reset_n = 1'b0;

    uart_rx_if bus ();

    uart_rx #(.OVERSAMPLE(16)) dut (
        .tick    (tick),
        .reset_n (reset_n),
        .rx      (bus)
    );

    always #5 tick = ~tick;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_valid  = 0;
    int   last_lat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, expv);
        end
    endtask

    // Frame-level scoreboard: every tick the outputs either hold the last
    // delivered result, pulse the next expected frame, or show reset values.
    initial begin : compare
        exp_t e;
        exp_t held;
        int   cyc;
        int   start_cyc;
        logic prev_active;
        logic prev_valid;
        held        = '{data: 8'h00, perr: 1'b0, ferr: 1'b0, lat: 0};
        cyc         = 0;
        start_cyc   = 0;
        prev_active = 1'b0;
        prev_valid  = 1'b0;
        forever begin
            @(posedge tick);
            #1;
            cyc++;
            if (!reset_n) begin
                chk("rst_data_out", 32'(bus.data_out), 0);
                chk("rst_data_valid", 32'(bus.data_valid), 0);
                chk("rst_parity_err", 32'(bus.parity_err), 0);
                chk("rst_frame_err", 32'(bus.frame_err), 0);
                chk("rst_rx_active", 32'(bus.rx_active), 0);
                held = '{data: 8'h00, perr: 1'b0, ferr: 1'b0, lat: 0};
            end else begin
                if (bus.rx_active && !prev_active) start_cyc = cyc;
                if (bus.data_valid) begin
                    chk("valid_one_tick", 32'(prev_valid), 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_out", 32'(bus.data_out), 32'(e.data));
                        chk("parity_err", 32'(bus.parity_err), 32'(e.perr));
                        chk("frame_err", 32'(bus.frame_err), 32'(e.ferr));
                        chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
                        last_lat = cyc - start_cyc;
                        held     = e;
                    end
                    n_valid++;
                end else begin
                    chk("hold_data_out", 32'(bus.data_out), 32'(held.data));
                    chk("hold_parity_err", 32'(bus.parity_err), 32'(held.perr));
                    chk("hold_frame_err", 32'(bus.frame_err), 32'(held.ferr));
                end
            end
            prev_active = bus.rx_active;
            prev_valid  = bus.data_valid;
        end
    end

    task automatic idle(input int n);
        bus.stream_in = 1'b1;
        repeat (n) @(negedge tick);
    endtask

    // Drives one frame; config inputs are scrambled from bit 2 onward to show
    // they are latched. abort_bit >= 0 pulses reset inside that frame bit.
    task automatic send_frame(input logic [7:0] data, input logic d8, input logic s2,
                              input logic [1:0] pm, input logic flip_par,
                              input logic stop1, input logic stop2,
                              input logic noisy, input int abort_bit);
        logic       bits[$];
        logic [7:0] dm;
        logic       pen;
        logic       pbit;
        exp_t       e;
        int         nd;
        nd   = d8 ? 8 : 7;
        dm   = d8 ? data : {1'b0, data[6:0]};
        pen  = (pm == PAR_EVEN) || (pm == PAR_ODD);
        pbit = (^dm) ^ (pm == PAR_ODD) ^ flip_par;
        bus.d_num = d8;
        bus.s_num = s2;
        bus.par   = pm;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(dm[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(stop1);
        if (s2) bits.push_back(stop2);
        e.data = dm;
        e.perr = pen && (((^dm) ^ pbit) != (pm == PAR_ODD));
        e.ferr = !stop1 || (s2 && !stop2);
        e.lat  = (1 + nd + (pen ? 1 : 0) + (s2 ? 2 : 1)) * 16 + 1;
        if (abort_bit < 0) exp_q.push_back(e);
        for (int b = 0; b < bits.size(); b++) begin
            if (b == 2) begin
                bus.d_num = ~d8;
                bus.s_num = ~s2;
                bus.par   = ~pm;
            end
            for (int t = 0; t < 16; t++) begin
                if (b == abort_bit && t == 4) begin
                    reset_n = 1'b0;
                    repeat (3) @(negedge tick);
                    reset_n       = 1'b1;
                    bus.stream_in = 1'b1;
                    return;
                end
                bus.stream_in = (noisy && b >= 1 && b <= nd && t == 9) ? ~bits[b] : bits[b];
                @(negedge tick);
            end
        end
        bus.stream_in = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        exp_t eb;
        int   v_before;
        bus.stream_in = 1'b1;
        bus.d_num     = 1'b1;
        bus.s_num     = 1'b0;
        bus.par       = PAR_NONE0;
        repeat (5) @(negedge tick);
        chk("lit_reset_data_out", 32'(bus.data_out), 0);
        chk("lit_reset_valid", 32'(bus.data_valid), 0);
        reset_n = 1'b1;
        idle(20);

        // 8N1 0xA5
        send_frame(8'hA5, 1'b1, 1'b0, PAR_NONE0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(30);
        chk("drain_a5", 32'(exp_q.size()), 0);
        chk("lit_a5_data", 32'(bus.data_out), 32'h0000_00A5);
        chk("lit_a5_latency", 32'(last_lat), 161);

        // 7E2 0x55, correct then flipped parity bit
        send_frame(8'h55, 1'b0, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(30);
        chk("drain_55", 32'(exp_q.size()), 0);
        chk("lit_55_data", 32'(bus.data_out), 32'h0000_0055);
        chk("lit_55_perr", 32'(bus.parity_err), 0);
        send_frame(8'h55, 1'b0, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        idle(30);
        chk("drain_55f", 32'(exp_q.size()), 0);
        chk("lit_55f_data", 32'(bus.data_out), 32'h0000_0055);
        chk("lit_55f_perr", 32'(bus.parity_err), 1);

        // False start: 5 low ticks only
        v_before      = n_valid;
        bus.stream_in = 1'b0;
        repeat (5) @(negedge tick);
        idle(40);
        chk("false_start_no_valid", 32'(n_valid), 32'(v_before));
        chk("false_start_idle", 32'(bus.rx_active), 0);

        // 8O2 0x96, second stop bit low
        send_frame(8'h96, 1'b1, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idle(30);
        chk("drain_96", 32'(exp_q.size()), 0);
        chk("lit_96_ferr", 32'(bus.frame_err), 1);
        chk("lit_96_perr", 32'(bus.parity_err), 0);

        // Break for 40 bit times in 8O2: all-zero frame, parity bit 0 is wrong for odd
        v_before  = n_valid;
        bus.d_num = 1'b1;
        bus.s_num = 1'b1;
        bus.par   = PAR_ODD;
        eb        = '{data: 8'h00, perr: 1'b1, ferr: 1'b1, lat: 193};
        exp_q.push_back(eb);
        bus.stream_in = 1'b0;
        repeat (40 * 16) @(negedge tick);
        idle(60);
        chk("drain_break", 32'(exp_q.size()), 0);
        chk("break_one_valid", 32'(n_valid - v_before), 1);

        // 8E1 0x3A with one flipped sample in every data bit
        send_frame(8'h3A, 1'b1, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        idle(30);
        chk("drain_noisy", 32'(exp_q.size()), 0);
        chk("lit_noisy_data", 32'(bus.data_out), 32'h0000_003A);

        // Reset during data bit 4 (frame bit 5), then a clean 0x3C
        v_before = n_valid;
        send_frame(8'hC3, 1'b1, 1'b0, PAR_NONE0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
        idle(40);
        chk("abort_no_valid", 32'(n_valid), 32'(v_before));
        chk("abort_data_out", 32'(bus.data_out), 0);
        send_frame(8'h3C, 1'b1, 1'b0, PAR_NONE0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(30);
        chk("drain_3c", 32'(exp_q.size()), 0);
        chk("lit_3c_data", 32'(bus.data_out), 32'h0000_003C);

        // 7-bit, par=11 (no parity): bit 7 must read 0
        send_frame(8'hFF, 1'b0, 1'b0, PAR_NONE3, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(30);
        chk("drain_7f", 32'(exp_q.size()), 0);
        chk("lit_7f_data", 32'(bus.data_out), 32'h0000_007F);
        chk("lit_7f_latency", 32'(last_lat), 145);

        chk("total_valid_count", 32'(n_valid), 8);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL expose parameter OVERSAMPLE, default 16, meaning tick periods per bit.
REQ-002 SHALL have port tick, input, 1: the single clock, at the 16x-baud oversampling rate; all state on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port stream_in, input, 1: serial line; idle high; asynchronous to tick.
REQ-005 SHALL have port d_num, input, 1: 0 = 7 data bits, 1 = 8 data bits.
REQ-006 SHALL have port s_num, input, 1: 0 = 1 stop bit, 1 = 2 stop bits.
REQ-007 SHALL have port par, input, 2: 00/11 = none, 01 = even, 10 = odd.
REQ-008 SHALL have port data_out, output, 8: received data, LSB first on the line; bit 7 = 0 in 7-bit mode.
REQ-009 SHALL have port data_valid, output, 1: one-tick pulse per completed frame.
REQ-010 SHALL have port parity_err, output, 1: parity mismatch in the last frame.
REQ-011 SHALL have port frame_err, output, 1: a stop bit sampled low in the last frame.
REQ-012 SHALL have port rx_active, output, 1: high in any state except IDLE.

Function
REQ-013 SHALL pass stream_in through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-015 SHALL keep a phase counter 0..15, cleared on every state entry and every bit boundary; it wraps 15->0 within DATA and STOP.
REQ-016 IDLE->START on a synchronized high->low transition, only while armed; armed sets on a synchronized high sample and clears on entering START.
REQ-017 SHALL form each bit value as the majority of the samples at phases 7, 8 and 9.
REQ-018 START at phase 15: majority 0 -> DATA; majority 1 -> IDLE (false start, no outputs change).
REQ-019 SHALL latch d_num, s_num and par on START->DATA; input changes mid-frame are ignored.
REQ-020 DATA SHALL collect 7 or 8 bits LSB first, then go to PARITY if parity is enabled, else to STOP.
REQ-021 PARITY SHALL take one bit; even: XOR of data and parity bit = 0; odd: XOR = 1; otherwise mismatch.
REQ-022 STOP SHALL take 1 or 2 bits; any stop-bit majority 0 sets the frame-error result.
REQ-023 After phase 15 of the last stop bit: go to DONE for exactly one tick, then IDLE.
REQ-024 In DONE: data_valid = 1; data_out, parity_err and frame_err update together and hold until the next DONE.
REQ-025 parity_err SHALL be 0 for a frame with no parity.
REQ-026 A frame_err frame SHALL still deliver data_out and data_valid.
REQ-027 A line held low (break) SHALL give at most one frame_err frame; no new start until the line is seen high (REQ-016).
REQ-028 Latency: data_valid SHALL assert (1+D+P+S)*16 + 1 ticks after the START-entry tick (D = data bits, P = parity bits, S = stop bits).

Reset
REQ-029 reset_n low SHALL force state IDLE, phase 0, synchronizer flops = 1, armed = 0, data_out = 0x00, data_valid = 0, parity_err = 0, frame_err = 0, rx_active = 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; data_valid SHALL NOT pulse for it.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum, the par encodings (PAR_NONE0/PAR_EVEN/PAR_ODD/PAR_NONE3) and OVERSAMPLE, shared with the transmitter.
REQ-032 Sub-module rx_bit_sampler SHALL contain the synchronizer, edge detect and 3-sample majority vote; uart_rx holds the FSM, counters and shift register.

Verification
REQ-033 8N1 frame 0xA5, no parity -> data_out = 0xA5, data_valid one tick, both errors 0, latency 161 ticks (per REQ-028).
REQ-034 d_num=0, even parity, 2 stop, data 0x55 with correct parity bit 0 -> data_out = 0x55, parity_err = 0; flip the parity bit -> parity_err = 1, data still 0x55.
REQ-035 Start pulse low for 5 ticks only -> return to IDLE, no data_valid, outputs unchanged.
REQ-036 Second stop bit driven low in 8O2 mode -> frame_err = 1, data_valid = 1; line held low for 40 bit times -> exactly one data_valid.
REQ-037 One noisy sample flipped at phase 8 of each data bit -> data still correct via majority.
REQ-038 reset_n asserted during bit 4 of a frame -> all outputs at reset values, no data_valid; next clean frame 0x3C is received correctly.
